// File: rtl/memory_arbiter.sv
// Two-port valid/ready arbiter sharing a single-ported, one-cycle-read memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; by default port 1 wins a tie.
module memory_arbiter #(
  parameter int unsigned BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  p0_req_valid_i,
  output logic                  p0_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr_i,
  input  logic                  p0_req_wr_i,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata_i,
  output logic                  p0_resp_valid_o,
  output logic [DATA_WIDTH-1:0] p0_resp_data_o,
  output logic                  p0_resp_err_o,
  input  logic                  p1_req_valid_i,
  output logic                  p1_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr_i,
  input  logic                  p1_req_wr_i,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata_i,
  output logic                  p1_resp_valid_o,
  output logic [DATA_WIDTH-1:0] p1_resp_data_o,
  output logic                  p1_resp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_cmd_addr_o,
  output logic                  mem_cmd_valid_o,
  output logic                  mem_wr_enable_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, CMD, RESP, ERR} state_e;

  localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

  state_e                state_q;
  logic                  reqPort_q;
  logic [ADDR_WIDTH-1:0] reqAddr_q;
  logic                  reqWr_q;
  logic [DATA_WIDTH-1:0] reqWdata_q;
  logic                  cmdValid_q;
  logic [1:0]            respValid_q;
  logic                  respErr_q;

  logic                  tieWinner;
  logic                  grant_d;
  logic                  accept_d;
  logic                  inRange_d;
  logic [ADDR_WIDTH-1:0] selAddr_d;
  logic [ADDR_WIDTH-1:0] offset_d;

`ifdef MEM_ARB_RR_EN
  logic lastGrant_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lastGrant_q <= 1'b1;
    end else if (accept_d) begin
      lastGrant_q <= grant_d;
    end
  end

  assign tieWinner = ~lastGrant_q;
`else
  assign tieWinner = 1'b1;
`endif

  // Grant is decided combinationally; nothing is accepted while reset is asserted.
  always_comb begin
    grant_d   = 1'b0;
    accept_d  = 1'b0;
    selAddr_d = '0;
    offset_d  = '0;
    inRange_d = 1'b0;
    if (p0_req_valid_i && p1_req_valid_i) begin
      grant_d = tieWinner;
    end else begin
      grant_d = p1_req_valid_i;
    end
    accept_d  = (state_q == IDLE) && !rst_i && (p0_req_valid_i || p1_req_valid_i);
    selAddr_d = grant_d ? p1_req_addr_i : p0_req_addr_i;
    offset_d  = selAddr_d - BASE_A;
    inRange_d = (selAddr_d >= BASE_A) && (offset_d < DEPTH_A);
  end

  assign p0_req_ready_o = accept_d && !grant_d;
  assign p1_req_ready_o = accept_d && grant_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      reqPort_q   <= 1'b0;
      reqAddr_q   <= '0;
      reqWr_q     <= 1'b0;
      reqWdata_q  <= '0;
      cmdValid_q  <= 1'b0;
      respValid_q <= '0;
      respErr_q   <= 1'b0;
    end else begin
      cmdValid_q  <= 1'b0;
      respValid_q <= '0;
      respErr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            reqPort_q  <= grant_d;
            reqAddr_q  <= selAddr_d;
            reqWr_q    <= grant_d ? p1_req_wr_i : p0_req_wr_i;
            reqWdata_q <= grant_d ? p1_req_wdata_i : p0_req_wdata_i;
            if (inRange_d) begin
              state_q    <= CMD;
              cmdValid_q <= 1'b1;
            end else begin
              state_q              <= ERR;
              respValid_q[grant_d] <= 1'b1;
              respErr_q            <= 1'b1;
            end
          end
        end
        CMD: begin
          state_q                <= RESP;
          respValid_q[reqPort_q] <= 1'b1;
        end
        RESP:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Command fields are forced to zero outside the command cycle.
  assign mem_cmd_valid_o = cmdValid_q;
  assign mem_cmd_addr_o  = cmdValid_q ? reqAddr_q : '0;
  assign mem_wr_enable_o = cmdValid_q && reqWr_q;
  assign mem_wr_data_o   = cmdValid_q ? reqWdata_q : '0;

  assign p0_resp_valid_o = respValid_q[0];
  assign p0_resp_err_o   = respValid_q[0] && respErr_q;
  assign p0_resp_data_o  = (respValid_q[0] && !respErr_q && !reqWr_q) ? mem_rd_data_i : '0;
  assign p1_resp_valid_o = respValid_q[1];
  assign p1_resp_err_o   = respValid_q[1] && respErr_q;
  assign p1_resp_data_o  = (respValid_q[1] && !respErr_q && !reqWr_q) ? mem_rd_data_i : '0;

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations. Honours MEM_ARB_RR_EN like the design.
module tb_memory_arbiter;

  localparam int unsigned BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned WORDS = DEPTH / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0Valid = 1'b0, p0Wr = 1'b0, p1Valid = 1'b0, p1Wr = 1'b0;
  logic [31:0] p0Addr = '0, p0Wdata = '0, p1Addr = '0, p1Wdata = '0;
  logic        p0Ready, p1Ready, p0RespValid, p1RespValid, p0RespErr, p1RespErr;
  logic [31:0] p0RespData, p1RespData;
  logic [31:0] memCmdAddr, memWrData, rdData;
  logic        memCmdValid, memWrEn, busy;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  memory_arbiter #(
    .BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .DATA_WIDTH(32), .ADDR_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_req_valid_i(p0Valid), .p0_req_ready_o(p0Ready), .p0_req_addr_i(p0Addr),
    .p0_req_wr_i(p0Wr), .p0_req_wdata_i(p0Wdata), .p0_resp_valid_o(p0RespValid),
    .p0_resp_data_o(p0RespData), .p0_resp_err_o(p0RespErr),
    .p1_req_valid_i(p1Valid), .p1_req_ready_o(p1Ready), .p1_req_addr_i(p1Addr),
    .p1_req_wr_i(p1Wr), .p1_req_wdata_i(p1Wdata), .p1_resp_valid_o(p1RespValid),
    .p1_resp_data_o(p1RespData), .p1_resp_err_o(p1RespErr),
    .mem_cmd_addr_o(memCmdAddr), .mem_cmd_valid_o(memCmdValid), .mem_wr_enable_o(memWrEn),
    .mem_wr_data_o(memWrData), .mem_rd_data_i(rdData), .busy_o(busy)
  );

  function automatic logic [31:0] preloadVal(input int k);
    if (k == 1) return 32'h5;
    if (k >= 16 && k < 32) return 32'(k - 15);
    return 32'hA000_0000 + 32'(k);
  endfunction

  // Memory environment: one-cycle read, write on the command edge.
  logic [31:0] memArr [WORDS];
  bit          memInit = 1'b1;
  always @(posedge clk) begin
    if (memInit) begin
      for (int k = 0; k < int'(WORDS); k++) memArr[k] <= preloadVal(k);
      rdData <= '0;
    end else if (memCmdValid && (memCmdAddr - BASE) < DEPTH) begin
      if (memWrEn) memArr[(memCmdAddr - BASE) >> 2] <= memWrData;
      else         rdData <= memArr[(memCmdAddr - BASE) >> 2];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted transaction owns the arbiter for a fixed window of cycles.
  bit          checkEn = 1'b0;
  longint      cyc = 0, cmdAt = -1, respAt = -1, idleFrom = 0;
  logic [31:0] refMem [WORDS];
  logic [31:0] mAddr, mWdata, mRespData, selA, selD;
  logic        mWr, mPort, mErr, mLast = 1'b1;
  logic        win, expR0, expR1, idleNow, isCmd, isResp, selW;
  longint      aL;

  always @(negedge clk) begin
    if (memInit)
      for (int k = 0; k < int'(WORDS); k++) refMem[k] = preloadVal(k);
    if (checkEn) begin
      idleNow = (cyc >= idleFrom) && !rst;
      if (p0Valid && p1Valid) begin
`ifdef MEM_ARB_RR_EN
        win = !mLast;
`else
        win = 1'b1;
`endif
      end else begin
        win = p1Valid;
      end
      expR0 = idleNow && p0Valid && !win;
      expR1 = idleNow && p1Valid && win;
      isCmd  = (cyc == cmdAt);
      isResp = (cyc == respAt);
      checkOutput("p0_ready", p0Ready, expR0);
      checkOutput("p1_ready", p1Ready, expR1);
      checkOutput("cmd_valid", memCmdValid, isCmd);
      checkOutput("cmd_addr", memCmdAddr, isCmd ? mAddr : 32'h0);
      checkOutput("cmd_wren", memWrEn, isCmd && mWr);
      checkOutput("cmd_wdata", memWrData, isCmd ? mWdata : 32'h0);
      checkOutput("p0_resp_valid", p0RespValid, isResp && !mPort);
      checkOutput("p0_resp_err", p0RespErr, isResp && !mPort && mErr);
      checkOutput("p0_resp_data", p0RespData, (isResp && !mPort) ? mRespData : 32'h0);
      checkOutput("p1_resp_valid", p1RespValid, isResp && mPort);
      checkOutput("p1_resp_err", p1RespErr, isResp && mPort && mErr);
      checkOutput("p1_resp_data", p1RespData, (isResp && mPort) ? mRespData : 32'h0);
      checkOutput("busy", busy, cyc < idleFrom);
      if (rst) begin
        cmdAt = -1; respAt = -1; idleFrom = cyc + 1; mLast = 1'b1;
      end else if ((expR0 && p0Valid) || (expR1 && p1Valid)) begin
        mPort = expR1;
        mLast = expR1;
        selA  = expR1 ? p1Addr : p0Addr;
        selW  = expR1 ? p1Wr : p0Wr;
        selD  = expR1 ? p1Wdata : p0Wdata;
        aL    = longint'(selA);
        if (aL >= longint'(BASE) && aL < longint'(BASE) + longint'(DEPTH)) begin
          mAddr = selA; mWr = selW; mWdata = selD; mErr = 1'b0;
          cmdAt = cyc + 1; respAt = cyc + 2; idleFrom = cyc + 3;
          if (selW) begin
            refMem[(aL - longint'(BASE)) / 4] = selD;
            mRespData = '0;
          end else begin
            mRespData = refMem[(aL - longint'(BASE)) / 4];
          end
        end else begin
          mErr = 1'b1; mRespData = '0;
          respAt = cyc + 1; idleFrom = cyc + 2;
        end
      end
      cyc++;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input bit port, input bit v, input logic [31:0] a, input bit w,
                        input logic [31:0] d);
    if (port) begin p1Valid = v; p1Addr = a; p1Wr = w; p1Wdata = d; end
    else      begin p0Valid = v; p0Addr = a; p0Wr = w; p0Wdata = d; end
  endtask

  // One complete transaction on a port; lat counts cycles from the accept edge to the response.
  task automatic applyStimulus(input bit port, input logic [31:0] addr, input bit wr,
                               input logic [31:0] wdata, output logic [31:0] data,
                               output bit err, output int lat);
    bit got = 1'b0;
    data = '0; err = 1'b0; lat = -1;
    setReq(port, 1'b1, addr, wr, wdata);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = port ? p1Ready : p0Ready;
      nextCycle();
    end
    setReq(port, 1'b0, addr, wr, wdata);
    if (!got) checkOutput("accept_timeout", 1'b0, 1'b1);
    for (int n = 0; n < 10 && lat < 0; n++) begin
      @(negedge clk);
      if (port ? p1RespValid : p0RespValid) begin
        data = port ? p1RespData : p0RespData;
        err  = port ? p1RespErr : p0RespErr;
        lat  = n;
      end
    end
    if (lat < 0) checkOutput("resp_timeout", 1'b0, 1'b1);
    nextCycle();
  endtask

  function automatic logic [31:0] randAddr();
    return BASE - 32'd16 + 32'd4 * 32'($urandom_range(0, WORDS + 7));
  endfunction

  logic [31:0] rData;
  bit          rErr, sawResp, pend0, pend1;
  int          rLat, accepted, nResp, tick, lastResp, nGr;
  bit          grants [4];

  initial begin
    repeat (3) nextCycle();
    checkEn = 1'b1;
    nextCycle();
    memInit = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_cmd_valid", memCmdValid, 1'b0);
    checkOutput("reset_p0_resp", p0RespValid, 1'b0);
    checkOutput("reset_p1_resp", p1RespValid, 1'b0);
    nextCycle();

    applyStimulus(1'b0, BASE + 4, 1'b0, 32'h0, rData, rErr, rLat);
    checkOutput("read_data", rData, 32'h5);
    checkOutput("read_err", rErr, 1'b0);
    checkOutput("read_latency", rLat, 1);

    applyStimulus(1'b1, BASE + 8, 1'b1, 32'hDEAD_BEEF, rData, rErr, rLat);
    checkOutput("write_data", rData, 32'h0);
    checkOutput("write_err", rErr, 1'b0);
    applyStimulus(1'b1, BASE + 8, 1'b0, 32'h0, rData, rErr, rLat);
    checkOutput("readback_data", rData, 32'hDEAD_BEEF);
    checkOutput("readback_err", rErr, 1'b0);

    applyStimulus(1'b0, BASE + DEPTH, 1'b0, 32'h0, rData, rErr, rLat);
    checkOutput("oor_hi_err", rErr, 1'b1);
    checkOutput("oor_hi_data", rData, 32'h0);
    checkOutput("oor_hi_latency", rLat, 0);
    applyStimulus(1'b1, BASE - 4, 1'b0, 32'h0, rData, rErr, rLat);
    checkOutput("oor_lo_err", rErr, 1'b1);
    applyStimulus(1'b0, BASE + DEPTH - 4, 1'b0, 32'h0, rData, rErr, rLat);
    checkOutput("last_word_err", rErr, 1'b0);
    checkOutput("last_word_data", rData, 32'hA000_003F);

    // p0 streams 16 sequential reads while holding valid.
    accepted = 0; nResp = 0; tick = 0; lastResp = 0;
    setReq(1'b0, 1'b1, BASE + 64, 1'b0, 32'h0);
    for (int i = 0; i < 100 && nResp < 16; i++) begin
      @(negedge clk);
      if (p0RespValid) begin
        checkOutput("b2b_data", p0RespData, 32'(nResp + 1));
        if (nResp > 0) checkOutput("b2b_gap", tick - lastResp, 3);
        lastResp = tick;
        nResp++;
      end
      if (p0Valid && p0Ready) accepted++;
      tick++;
      nextCycle();
      if (accepted == 16) p0Valid = 1'b0;
      else p0Addr = BASE + 64 + 32'(4 * accepted);
    end
    checkOutput("b2b_count", nResp, 16);
    nextCycle();

    // Reset during the command cycle drops the transaction.
    setReq(1'b0, 1'b1, BASE, 1'b0, 32'h0);
    for (int i = 0; i < 10 && !p0Ready; i++) @(negedge clk);
    nextCycle();
    rst = 1'b1; p0Valid = 1'b0;
    nextCycle();
    rst = 1'b0;
    sawResp = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy", busy, 1'b0);
    checkOutput("midreset_cmd_valid", memCmdValid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (p0RespValid || p1RespValid) sawResp = 1'b1;
      @(negedge clk);
    end
    checkOutput("midreset_no_resp", sawResp, 1'b0);
    nextCycle();

    // Both ports request continuously straight after reset.
    nGr = 0;
    setReq(1'b0, 1'b1, BASE, 1'b0, 32'h0);
    setReq(1'b1, 1'b1, BASE + 4, 1'b0, 32'h0);
    for (int i = 0; i < 40 && nGr < 4; i++) begin
      @(negedge clk);
      if (p0Ready) begin grants[nGr] = 1'b0; nGr++; end
      else if (p1Ready) begin grants[nGr] = 1'b1; nGr++; end
      nextCycle();
    end
    p0Valid = 1'b0; p1Valid = 1'b0;
    checkOutput("contention_count", nGr, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      checkOutput("contention_grant", grants[i], 1'(i % 2));
`else
      checkOutput("contention_grant", grants[i], 1'b1);
`endif
    end
    repeat (4) nextCycle();

    // Randomized traffic with occasional resets; every cycle is checked against the model.
    pend0 = 1'b0; pend1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!pend0) begin
        p0Valid = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          pend0 = 1'b1;
          setReq(1'b0, 1'b1, randAddr(), 1'($urandom_range(0, 1)), $urandom);
        end
      end
      if (!pend1) begin
        p1Valid = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          pend1 = 1'b1;
          setReq(1'b1, 1'b1, randAddr(), 1'($urandom_range(0, 1)), $urandom);
        end
      end
      rst = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      if (p0Valid && p0Ready) pend0 = 1'b0;
      if (p1Valid && p1Ready) pend1 = 1'b0;
      nextCycle();
    end
    rst = 1'b0; p0Valid = 1'b0; p1Valid = 1'b0;
    repeat (5) nextCycle();
    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Two-requester arbiter that shares the single-ported, one-cycle-read memory model between instruction fetch (port 0) and data access (port 1).
- Accepts valid/ready requests, issues one memory command at a time and returns a one-cycle response pulse to the owning port.
- Range-checks addresses, so out-of-range accesses never reach memory.
- Sits between core fetch/LSU and the memory model in simulation and FPGA top.

Parameters:
BASE_ADDR, `BELLEK_BASLANGIC, first byte address mapped to memory
MEM_DEPTH, `BELLEK_BOYUT, memory size in bytes; valid range [BASE_ADDR, BASE_ADDR+MEM_DEPTH)
DATA_WIDTH, `VERI_BIT, data width in bits
ADDR_WIDTH, `ADRES_BIT, address width in bits

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
p0_req_valid_i  in  1  port 0 request valid
p0_req_ready_o  out  1  port 0 request accepted when valid&ready at edge
p0_req_addr_i  in  ADDR_WIDTH  port 0 byte address
p0_req_wr_i  in  1  1 = write, 0 = read
p0_req_wdata_i  in  DATA_WIDTH  port 0 write data
p0_resp_valid_o  out  1  one-cycle response pulse
p0_resp_data_o  out  DATA_WIDTH  read data, 0 for writes/errors
p0_resp_err_o  out  1  address out of range, qualified by resp_valid
p1_*  same set as p0_* for port 1
mem_cmd_addr_o  out  ADDR_WIDTH  memory command address
mem_cmd_valid_o  out  1  memory command valid
mem_wr_enable_o  out  1  memory write enable
mem_wr_data_o  out  DATA_WIDTH  memory write data
mem_rd_data_i  in  DATA_WIDTH  memory read data, valid the cycle after the command edge
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset:
  - Clock is clk_i; reset rst_i is synchronous and active-high.
  - State = IDLE; all outputs 0 except pX_req_ready_o, which follows IDLE rules from the first cycle after reset.
  - Reset mid-transaction drops the transaction: no response, mem_cmd_valid_o = 0 the next cycle.
- FSM states: IDLE, CMD, RESP, ERR.
- IDLE:
  - Grant is combinational. Ready is asserted only to the granted port, and only when that port's valid is high; the other port's ready = 0.
  - On accept, latch port id, addr, wr, wdata.
  - In range -> CMD; out of range -> ERR.
- CMD (1 cycle): mem_cmd_valid_o = 1; addr, wr_enable and wr_data come from the latched registers. Next state RESP.
- RESP (1 cycle):
  - Owner's resp_valid_o = 1; resp_data_o = mem_rd_data_i for reads, 0 for writes; resp_err_o = 0.
  - Next state IDLE.
- ERR (1 cycle): owner's resp_valid_o = 1, resp_err_o = 1, resp_data_o = 0; no memory command. Next state IDLE.
- Latency (accept edge = T0):
  - In range: command visible in cycle T0..T1, response in cycle T1..T2, ready again in cycle T2..T3. One transaction per 3 cycles.
  - Error: response in cycle T0..T1, ready again in cycle T1..T2.
- Ready never asserts outside IDLE. Requests held valid across busy cycles are accepted on return to IDLE, with no loss or duplication.
- Range check uses unsigned compare: addr >= BASE_ADDR and (addr - BASE_ADDR) < MEM_DEPTH. The upper bound is exclusive; BASE_ADDR+MEM_DEPTH-DATA_WIDTH/8 is the last legal word.
- Outputs of the non-owning port stay 0 while another transaction is in flight.
- Default arbitration (macro off): fixed priority, port 1 (data) wins a simultaneous request.

Optional Feature:
MEM_ARB_RR_EN:
- Defined: round-robin arbitration. A last-grant register (reset value 1, so port 0 wins the first tie) is updated on every accept. On a simultaneous request, the port not granted last wins.
- Undefined: fixed priority, port 1 over port 0; no last-grant register.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Single read: p0 read at BASE_ADDR+4 with memory word 0x5 preloaded -> mem_cmd_valid_o one cycle after accept, p0_resp_valid_o one cycle later, data 0x5, err 0, busy_o high 2 cycles.
- Write then read on p1: write 0xDEADBEEF at BASE_ADDR+8, then read the same address -> write resp data 0, err 0; read resp data 0xDEADBEEF.
- Out of range: p0 read at BASE_ADDR+MEM_DEPTH -> no mem_cmd_valid_o; p0_resp_valid_o and p0_resp_err_o high in the cycle after accept, data 0.
- Contention: p0 and p1 both request continuously for 4 transactions.
  - Macro off: p1 gets all 4 grants.
  - MEM_ARB_RR_EN: grants alternate p0, p1, p0, p1.
- Reset mid-op: assert rst_i during the CMD cycle -> no resp pulse on either port; next cycle state IDLE, all outputs 0.
- Back-to-back: p0 holds valid for 16 sequential reads (addr +VERI_BYTE each) -> 16 responses in order, exactly 3 cycles apart, matching preloaded i+1 data.
